// File: rtl/n2m_rr_arb.sv
// rtl/n2m_rr_arb.sv - N-requester round-robin arbiter with registered one-hot grant, hold timeout and rotating start pointer
// The encoded index downstream must be qualified with Gnt_Vld_o, since grant bit 0 and no grant both encode to 0.
module n2m_rr_arb #(
  parameter int N   = 42,
  parameter int M   = 6,
  parameter int TMO = 200
) (
  input  logic         Clk_i,
  input  logic         Rst_i,
  input  logic [N-1:0] Req_i,
  input  logic         Rel_i,
  output logic [N-1:0] Gnt_Oh_o,
  output logic         Gnt_Vld_o,
  output logic [M-1:0] Ptr_o,
  output logic         Tmo_o
);

  localparam int CW = 8;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t         state_q, state_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic [M-1:0]   idx_q, idx_nxt;
  logic [M-1:0]   ptr_q, ptr_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;
  logic           tmo_q, tmo_nxt;

  logic           found;
  logic [M-1:0]   win_idx;
  logic [N-1:0]   win_oh;
  logic           expire;

  // Rotating priority search: first set request at or above ptr_q, wrapping past N-1.
  always_comb begin
    int j;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && Req_i[j]) begin
        found   = 1'b1;
        win_idx = M'(j);
      end
    end
    for (int i = 0; i < N; i++) begin
      win_oh[i] = found && (win_idx == M'(i));
    end
  end

  assign expire = (cnt_q == CW'(TMO - 1));

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    tmo_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_nxt = HOLD;
          gnt_nxt   = win_oh;
          idx_nxt   = win_idx;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (Rel_i || expire) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (idx_q == M'(N - 1)) ? '0 : idx_q + M'(1);
          cnt_nxt   = '0;
          // An explicit release in the expiry cycle is a normal release, not a timeout.
          tmo_nxt   = !Rel_i;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      idx_q   <= idx_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  assign Gnt_Oh_o  = gnt_q;
  assign Gnt_Vld_o = (state_q == HOLD);
  assign Ptr_o     = ptr_q;
  assign Tmo_o     = tmo_q;

endmodule
